// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NCTRL controllers share one peripheral port.
// The grant is held until the cycle ends by ack, abort or watchdog timeout.
module wb_arbiter #(
   parameter int NCTRL   = 2,
   parameter int ADR_W   = 4,
   parameter int DAT_W   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCTRL-1:0]         c_stb,
   input  logic [NCTRL-1:0]         c_we,
   input  logic [NCTRL*ADR_W-1:0]   c_adr,
   input  logic [NCTRL*DAT_W-1:0]   c_dat_c,
   output logic [NCTRL-1:0]         c_ack,
   output logic [DAT_W-1:0]         c_dat_p,
   output logic                     p_stb,
   output logic                     p_we,
   output logic [ADR_W-1:0]         p_adr,
   output logic [DAT_W-1:0]         p_dat_c,
   input  logic                     p_ack,
   input  logic [DAT_W-1:0]         p_dat_p,
   output logic [NCTRL-1:0]         grant,
   output logic                     tmo_err,
   input  logic                     tmo_clr
);

   // state | meaning
   // IDLE  | no owner; arbitrate among requesters this cycle
   // BUSY  | controller last_q owns the peripheral until ack/abort/timeout

   localparam int LW = (NCTRL > 1) ? $clog2(NCTRL) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // The watchdog fires on the TIMEOUT-th BUSY cycle, i.e. when the count
   // of already elapsed unacked cycles equals TIMEOUT-1.
   localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [NCTRL-1:0] grant_q, grant_d;
   logic [LW-1:0]    last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             tmo_err_q, tmo_err_d;

   logic             busy;
   logic             stb_g;
   logic             tmo_fire;
   logic             req_found;
   logic [LW-1:0]    pick;

   assign busy     = (state_q == BUSY);
   assign stb_g    = c_stb[last_q];
   assign tmo_fire = (TIMEOUT > 0) && busy && stb_g && !p_ack && (cnt_q == TMO_LAST);
   assign grant    = grant_q;
   assign tmo_err  = tmo_err_q;

   // Round-robin search: first requester after the previous owner.
   always_comb begin
      int idx;
      idx       = 0;
      pick      = last_q;
      req_found = 1'b0;
      for (int k = 1; k <= NCTRL; k++) begin
         idx = (int'(last_q) + k) % NCTRL;
         if (!req_found && c_stb[idx]) begin
            pick      = LW'(idx);
            req_found = 1'b1;
         end
      end
   end

   // Peripheral and controller side muxing for the current owner.
   always_comb begin
      p_stb   = busy & stb_g & ~tmo_fire;
      p_we    = busy & c_we[last_q];
      p_adr   = busy ? c_adr[last_q*ADR_W +: ADR_W] : '0;
      p_dat_c = c_dat_c[last_q*DAT_W +: DAT_W];
      c_ack   = '0;
      if (busy && stb_g && (p_ack || tmo_fire))
         c_ack = grant_q;
      c_dat_p = tmo_fire ? '0 : p_dat_p;
   end

   // Next-state: arbitration, cycle termination, watchdog and error flag.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      tmo_err_d = tmo_err_q;
      if (tmo_clr)
         tmo_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_found) begin
               state_d       = BUSY;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               last_d        = pick;
               cnt_d         = '0;
            end
         end
         BUSY: begin
            if (!stb_g || p_ack || tmo_fire) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
               if (tmo_fire)
                  tmo_err_d = 1'b1;
            end else if (TIMEOUT > 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= LW'(NCTRL - 1);
         cnt_q     <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (NCTRL=2, ADR_W=4, DAT_W=8, TIMEOUT=15).
module tb_wb_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  c_stb, c_we, c_ack, grant;
   logic [7:0]  c_adr;
   logic [15:0] c_dat_c;
   logic [7:0]  c_dat_p, p_dat_c, p_dat_p;
   logic        p_stb, p_we, p_ack, tmo_err, tmo_clr;
   logic [3:0]  p_adr;

   int checks = 0;
   int errors = 0;

   wb_arbiter #(.NCTRL(2), .ADR_W(4), .DAT_W(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .c_stb(c_stb), .c_we(c_we), .c_adr(c_adr),
      .c_dat_c(c_dat_c), .c_ack(c_ack), .c_dat_p(c_dat_p), .p_stb(p_stb),
      .p_we(p_we), .p_adr(p_adr), .p_dat_c(p_dat_c), .p_ack(p_ack),
      .p_dat_p(p_dat_p), .grant(grant), .tmo_err(tmo_err), .tmo_clr(tmo_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  stb;
      logic [1:0]  we;
      logic [7:0]  adr;
      logic [15:0] datc;
      logic        pack;
      logic [7:0]  pdat;
      logic        clr;
      logic [1:0]  e_grant;
      logic        e_pstb;
      logic [1:0]  e_ack;
      logic [7:0]  e_cdat;
      logic        e_err;
      logic [3:0]  e_padr;
   } vec_t;

   vec_t vt[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] stb, input logic [1:0] we,
                        input logic [7:0] adr, input logic [15:0] datc, input logic pack,
                        input logic [7:0] pdat, input logic clr);
      rst = r; c_stb = stb; c_we = we; c_adr = adr; c_dat_c = datc;
      p_ack = pack; p_dat_p = pdat; tmo_clr = clr;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // {rst,stb,we,adr,datc,pack,pdat,clr, grant,pstb,ack,cdat,err,padr}
      vt[0]  = '{1'b0, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0};
      // single read by ctrl0, ack two cycles after p_stb rises
      vt[1]  = '{1'b1, 2'b01, 2'b00, 8'h03, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0};
      vt[2]  = '{1'b1, 2'b01, 2'b00, 8'h03, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 2'b00, 8'h00, 1'b0, 4'h3};
      vt[3]  = '{1'b1, 2'b01, 2'b00, 8'h03, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 2'b00, 8'h00, 1'b0, 4'h3};
      vt[4]  = '{1'b1, 2'b01, 2'b00, 8'h03, 16'h0000, 1'b1, 8'hA5, 1'b0, 2'b01, 1'b1, 2'b01, 8'hA5, 1'b0, 4'h3};
      vt[5]  = '{1'b1, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h11, 1'b0, 2'b00, 1'b0, 2'b00, 8'h11, 1'b0, 4'h0};
      // both request continuously, immediate ack: alternating grants
      vt[6]  = '{1'b1, 2'b11, 2'b00, 8'h21, 16'h0000, 1'b1, 8'h10, 1'b0, 2'b00, 1'b0, 2'b00, 8'h10, 1'b0, 4'h0};
      vt[7]  = '{1'b1, 2'b11, 2'b00, 8'h21, 16'h0000, 1'b1, 8'h10, 1'b0, 2'b10, 1'b1, 2'b10, 8'h10, 1'b0, 4'h2};
      vt[8]  = '{1'b1, 2'b11, 2'b00, 8'h21, 16'h0000, 1'b1, 8'h10, 1'b0, 2'b00, 1'b0, 2'b00, 8'h10, 1'b0, 4'h0};
      vt[9]  = '{1'b1, 2'b11, 2'b00, 8'h21, 16'h0000, 1'b1, 8'h10, 1'b0, 2'b01, 1'b1, 2'b01, 8'h10, 1'b0, 4'h1};
      vt[10] = '{1'b1, 2'b11, 2'b00, 8'h21, 16'h0000, 1'b1, 8'h10, 1'b0, 2'b00, 1'b0, 2'b00, 8'h10, 1'b0, 4'h0};
      vt[11] = '{1'b1, 2'b11, 2'b00, 8'h21, 16'h0000, 1'b1, 8'h10, 1'b0, 2'b10, 1'b1, 2'b10, 8'h10, 1'b0, 4'h2};
      vt[12] = '{1'b1, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0};
      // ctrl0 aborts after 3 busy cycles, late ack ignored
      vt[13] = '{1'b1, 2'b01, 2'b00, 8'h05, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0};
      vt[14] = '{1'b1, 2'b01, 2'b00, 8'h05, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 2'b00, 8'h00, 1'b0, 4'h5};
      vt[15] = '{1'b1, 2'b01, 2'b00, 8'h05, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 2'b00, 8'h00, 1'b0, 4'h5};
      vt[16] = '{1'b1, 2'b01, 2'b00, 8'h05, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 2'b00, 8'h00, 1'b0, 4'h5};
      vt[17] = '{1'b1, 2'b00, 2'b00, 8'h05, 16'h0000, 1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 2'b00, 8'h00, 1'b0, 4'h5};
      vt[18] = '{1'b1, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h77, 1'b0, 2'b00, 1'b0, 2'b00, 8'h77, 1'b0, 4'h0};

      drive(1'b0, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      tick();
      tick();

      for (int i = 0; i < 19; i++) begin
         drive(vt[i].rst, vt[i].stb, vt[i].we, vt[i].adr, vt[i].datc,
               vt[i].pack, vt[i].pdat, vt[i].clr);
         chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vt[i].e_grant));
         chk($sformatf("vec%0d p_stb", i), 32'(p_stb), 32'(vt[i].e_pstb));
         chk($sformatf("vec%0d c_ack", i), 32'(c_ack), 32'(vt[i].e_ack));
         chk($sformatf("vec%0d c_dat_p", i), 32'(c_dat_p), 32'(vt[i].e_cdat));
         chk($sformatf("vec%0d tmo_err", i), 32'(tmo_err), 32'(vt[i].e_err));
         chk($sformatf("vec%0d p_adr", i), 32'(p_adr), 32'(vt[i].e_padr));
         tick();
      end

      // ctrl1 write, peripheral never acks: forced ack on 15th busy cycle
      drive(1'b1, 2'b10, 2'b10, 8'h70, 16'h5C00, 1'b0, 8'hEE, 1'b0);
      chk("t3 idle grant", 32'(grant), 32'h0);
      tick();
      for (int i = 1; i <= 15; i++) begin
         drive(1'b1, 2'b10, 2'b10, 8'h70, 16'h5C00, 1'b0, 8'hEE, 1'b0);
         chk($sformatf("t3 cyc%0d grant", i), 32'(grant), 32'h2);
         if (i < 15) begin
            chk($sformatf("t3 cyc%0d c_ack", i), 32'(c_ack), 32'h0);
            chk($sformatf("t3 cyc%0d p_stb", i), 32'(p_stb), 32'h1);
         end else begin
            chk("t3 forced c_ack", 32'(c_ack), 32'h2);
            chk("t3 forced p_stb", 32'(p_stb), 32'h0);
            chk("t3 forced c_dat_p", 32'(c_dat_p), 32'h0);
         end
         if (i == 1) begin
            chk("t3 p_we", 32'(p_we), 32'h1);
            chk("t3 p_adr", 32'(p_adr), 32'h7);
            chk("t3 p_dat_c", 32'(p_dat_c), 32'h5C);
         end
         tick();
      end
      drive(1'b1, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("t3 after grant", 32'(grant), 32'h0);
      chk("t3 tmo_err set", 32'(tmo_err), 32'h1);
      tick();
      drive(1'b1, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1);
      chk("t3 tmo_err before clr", 32'(tmo_err), 32'h1);
      tick();
      drive(1'b1, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("t3 tmo_err cleared", 32'(tmo_err), 32'h0);
      tick();

      // p_ack lands exactly on the timeout cycle: normal completion
      drive(1'b1, 2'b01, 2'b00, 8'h09, 16'h0000, 1'b0, 8'h00, 1'b0);
      tick();
      for (int i = 1; i <= 15; i++) begin
         drive(1'b1, 2'b01, 2'b00, 8'h09, 16'h0000, (i == 15), (i == 15) ? 8'h3C : 8'h00, 1'b0);
         if (i < 15) begin
            chk($sformatf("t6 cyc%0d c_ack", i), 32'(c_ack), 32'h0);
         end else begin
            chk("t6 c_ack", 32'(c_ack), 32'h1);
            chk("t6 c_dat_p", 32'(c_dat_p), 32'h3C);
            chk("t6 p_stb", 32'(p_stb), 32'h1);
         end
         tick();
      end
      drive(1'b1, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("t6 tmo_err", 32'(tmo_err), 32'h0);
      chk("t6 grant", 32'(grant), 32'h0);
      tick();

      // timeout while tmo_clr is held high: the set wins
      drive(1'b1, 2'b10, 2'b00, 8'h40, 16'h0000, 1'b0, 8'h00, 1'b1);
      tick();
      for (int i = 1; i <= 15; i++) begin
         drive(1'b1, 2'b10, 2'b00, 8'h40, 16'h0000, 1'b0, 8'h00, 1'b1);
         if (i == 15)
            chk("set-wins c_ack", 32'(c_ack), 32'h2);
         tick();
      end
      drive(1'b1, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("set-wins tmo_err", 32'(tmo_err), 32'h1);
      tick();

      // reset during ctrl1's busy cycle
      drive(1'b1, 2'b10, 2'b00, 8'h40, 16'h0000, 1'b0, 8'h00, 1'b0);
      tick();
      drive(1'b1, 2'b10, 2'b00, 8'h40, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("t5 busy grant", 32'(grant), 32'h2);
      chk("t5 busy p_stb", 32'(p_stb), 32'h1);
      tick();
      drive(1'b0, 2'b10, 2'b00, 8'h40, 16'h0000, 1'b0, 8'h00, 1'b0);
      tick();
      drive(1'b1, 2'b11, 2'b00, 8'h40, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("t5 p_stb", 32'(p_stb), 32'h0);
      chk("t5 grant", 32'(grant), 32'h0);
      chk("t5 tmo_err", 32'(tmo_err), 32'h0);
      chk("t5 c_ack", 32'(c_ack), 32'h0);
      tick();
      drive(1'b1, 2'b11, 2'b00, 8'h40, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("t5 first grant", 32'(grant), 32'h1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
